// File: rtl/inst_issue_buffer.sv
// Instruction buffer and in-order issue stage feeding the decoder.
// The host loads a program while idle; start issues it one word per non-stalled cycle.
module inst_issue_buffer #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6,
    parameter int unsigned IW    = 25
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic          clear,
    input  logic          start,
    input  logic          stall,
    output logic [IW-1:0] opcode,
    output logic          opcode_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
);

    // pc and len need one extra bit so a full buffer never wraps mid-program
    localparam int unsigned LW = AW + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] pc_q, pc_d;
    logic [LW-1:0] load_end;
    logic [IW-1:0] opcode_d;
    logic          valid_d;
    logic          busy_d;
    logic          done_d;
    logic          load_acc;

    logic [IW-1:0] mem [DEPTH];

    assign load_acc = load_en && (state_q == S_IDLE);
    assign load_end = LW'(load_addr) + LW'(1);
    assign pc       = pc_q[AW-1:0];

    // Program storage: not reset, written only while idle
    always_ff @(posedge clk) begin
        if (load_acc) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            pc_q         <= '0;
            opcode       <= '0;
            opcode_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            pc_q         <= pc_d;
            opcode       <= opcode_d;
            opcode_valid <= valid_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        pc_d     = pc_q;
        opcode_d = opcode;
        valid_d  = opcode_valid;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_en && (load_end > len_q)) begin
                    len_d = load_end;
                end
                // clear wins over a same-cycle load for the length only
                if (clear) begin
                    len_d = '0;
                end
                if (start && !load_en && !clear) begin
                    if (len_q != '0) begin
                        state_d  = S_RUN;
                        opcode_d = mem[0];
                        valid_d  = 1'b1;
                        pc_d     = LW'(1);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (pc_q < len_q) begin
                        opcode_d = mem[pc_q[AW-1:0]];
                        pc_d     = pc_q + LW'(1);
                    end else begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        pc_d    = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
    end

endmodule

// File: tb/tb_inst_issue_buffer.sv
// Self-checking bench for inst_issue_buffer: directed scenarios plus random traffic,
// checked every cycle against a queue/index-level model of the program and its issue order.
module tb_inst_issue_buffer;

    logic        clk;
    logic        rst_n;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [24:0] load_data;
    logic        clear;
    logic        start;
    logic        stall;
    logic [24:0] opcode;
    logic        opcode_valid;
    logic [5:0]  pc;
    logic        busy;
    logic        done;

    inst_issue_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .clear        (clear),
        .start        (start),
        .stall        (stall),
        .opcode       (opcode),
        .opcode_valid (opcode_valid),
        .pc           (pc),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: the program as an array plus its length; a run is "index of the word on opcode"
    logic [24:0] m_mem [64];
    int          m_len;
    bit          m_run;
    int          m_idx;
    logic [24:0] m_opcode;
    bit          m_valid;
    bit          m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int exp_pc;
        exp_pc = m_run ? ((m_idx + 1) % 64) : 0;
        chk({tag, ".opcode"}, 32'(opcode), 32'(m_opcode));
        chk({tag, ".valid"},  32'(opcode_valid), 32'(m_valid));
        chk({tag, ".pc"},     32'(pc), 32'(exp_pc));
        chk({tag, ".busy"},   32'(busy), 32'(m_run));
        chk({tag, ".done"},   32'(done), 32'(m_done));
    endtask

    task automatic model_reset();
        m_len    = 0;
        m_run    = 0;
        m_idx    = 0;
        m_opcode = '0;
        m_valid  = 0;
        m_done   = 0;
    endtask

    // One clock: drive at negedge, advance model, check shortly after the rising edge
    task automatic cycle(input bit le, input logic [5:0] a, input logic [24:0] d,
                         input bit clr, input bit st, input bit stl, input string tag);
        @(negedge clk);
        load_en   = le;
        load_addr = a;
        load_data = d;
        clear     = clr;
        start     = st;
        stall     = stl;
        m_done = 0;
        if (!m_run) begin
            if (le) begin
                m_mem[a] = d;
                if (int'(a) + 1 > m_len) m_len = int'(a) + 1;
            end
            if (clr) m_len = 0;
            if (st && !le && !clr) begin
                if (m_len > 0) begin
                    m_run    = 1;
                    m_idx    = 0;
                    m_opcode = m_mem[0];
                    m_valid  = 1;
                end else begin
                    m_done = 1;
                end
            end
        end else if (!stl) begin
            if (m_idx + 1 < m_len) begin
                m_idx++;
                m_opcode = m_mem[m_idx];
            end else begin
                m_run   = 0;
                m_valid = 0;
                m_done  = 1;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, 0, 0, tag);
    endtask

    task automatic load(input logic [5:0] a, input logic [24:0] d);
        cycle(1, a, d, 0, 0, 0, "load");
    endtask

    initial begin
        rst_n = 1'b0;
        load_en = 0; load_addr = '0; load_data = '0;
        clear = 0; start = 0; stall = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Give every slot known contents, then forget the program
        for (int i = 0; i < 64; i++) load(6'(i), 25'($urandom));
        cycle(0, '0, '0, 1, 0, 0, "clear0");

        // Four-word program, no stall
        load(6'd0, 25'h0000001);
        load(6'd1, 25'h0800002);
        load(6'd2, 25'h1000003);
        load(6'd3, 25'h1800004);
        cycle(0, '0, '0, 0, 1, 0, "run4.start");
        idle(6, "run4");

        // Same program, stall for 3 cycles while word 1 is on opcode
        cycle(0, '0, '0, 0, 1, 0, "stall.start");
        cycle(0, '0, '0, 0, 0, 0, "stall.w1");
        for (int i = 0; i < 3; i++) cycle(0, '0, '0, 0, 0, 1, "stall.hold");
        idle(6, "stall");

        // clear then start: done only
        cycle(0, '0, '0, 1, 0, 0, "clr");
        cycle(0, '0, '0, 0, 1, 0, "clr.start");
        idle(2, "clr");

        // start with load_en: load wins, len becomes 1
        cycle(1, 6'd0, 25'h0ABCDEF, 0, 1, 0, "ldstart");
        idle(1, "ldstart");
        cycle(0, '0, '0, 0, 1, 0, "len1.start");
        idle(3, "len1");

        // Slot 63 only gives a 64-word program with pc wrapping to 0 only at the end
        cycle(0, '0, '0, 1, 0, 0, "clr63");
        load(6'd63, 25'h1234567);
        cycle(0, '0, '0, 0, 1, 0, "full.start");
        idle(66, "full");

        // Loads and start during RUN are ignored
        cycle(0, '0, '0, 1, 0, 0, "clrrun");
        load(6'd0, 25'h0000011);
        load(6'd1, 25'h0000022);
        load(6'd2, 25'h0000033);
        cycle(0, '0, '0, 0, 1, 0, "ign.start");
        cycle(1, 6'd0, 25'h1FFFFFF, 0, 0, 0, "ign.load");
        cycle(0, '0, '0, 0, 1, 0, "ign.restart");
        idle(3, "ign");
        cycle(0, '0, '0, 0, 1, 0, "rerun.start");
        idle(4, "rerun");

        // Asynchronous reset mid-run
        cycle(0, '0, '0, 0, 1, 0, "rst.start");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst.async");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, '0, '0, 0, 1, 0, "rst.start2");
        idle(2, "rst.after");

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bit          le, clr, st, stl;
            logic [5:0]  a;
            le  = ($urandom % 4) == 0;
            clr = ($urandom % 24) == 0;
            st  = ($urandom % 6) == 0;
            stl = ($urandom % 3) == 0;
            a   = (($urandom % 10) == 0) ? 6'($urandom) : 6'($urandom_range(0, 11));
            cycle(le, a, 25'($urandom), clr, st, stl, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
